// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// matmul_sequencer: computes C = A x B one element at a time via MAC cycles,
// writing each element to the register file. MATMUL_SEQ_SAT_EN: saturating acc.
// Revision: 1.0
// ============================================================================
module matmul_sequencer #(
    parameter int ROWS  = 2,
    parameter int COLS  = 4,
    parameter int INNER = 2,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic [3:0]    a_addr,
    output logic [3:0]    b_addr,
    output logic [DW-1:0] product_out,
    output logic [3:0]    reg_specifier,
    output logic          update_reg,
    output logic          busy,
    output logic          done
);

    localparam logic [3:0] c_rows_m1  = 4'(ROWS - 1);
    localparam logic [3:0] c_cols     = 4'(COLS);
    localparam logic [3:0] c_cols_m1  = 4'(COLS - 1);
    localparam logic [3:0] c_inner    = 4'(INNER);
    localparam logic [3:0] c_inner_m1 = 4'(INNER - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_i;
    logic [3:0]    r_j;
    logic [3:0]    r_k;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_next;

`ifdef MATMUL_SEQ_SAT_EN
    logic [2*DW-1:0] w_prod;
    logic [2*DW-1:0] w_sum;

    assign w_prod     = {{DW{1'b0}}, a_data} * {{DW{1'b0}}, b_data};
    assign w_sum      = w_prod + {{DW{1'b0}}, r_acc};
    // Once pinned at full scale, non-negative products keep it there.
    assign w_acc_next = (w_sum > {{DW{1'b0}}, {DW{1'b1}}}) ? {DW{1'b1}} : w_sum[DW-1:0];
`else
    // Low DW bits of the truncated sum depend only on the low bits of the product.
    assign w_acc_next = a_data * b_data + r_acc;
`endif

    assign a_addr = r_i * c_inner + r_k;
    assign b_addr = r_k * c_cols + r_j;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_i           <= 4'd0;
            r_j           <= 4'd0;
            r_k           <= 4'd0;
            r_acc         <= '0;
            product_out   <= '0;
            reg_specifier <= 4'd0;
            update_reg    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    update_reg <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        r_state <= S_MAC;
                        r_i     <= 4'd0;
                        r_j     <= 4'd0;
                        r_k     <= 4'd0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_k == c_inner_m1) begin
                        r_k           <= 4'd0;
                        product_out   <= w_acc_next;
                        reg_specifier <= r_i * c_cols + r_j;
                        update_reg    <= 1'b1;
                        r_state       <= S_WRITE;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_WRITE: begin
                    update_reg <= 1'b0;
                    r_acc      <= '0;
                    if (r_i == c_rows_m1 && r_j == c_cols_m1) begin
                        r_i     <= 4'd0;
                        r_j     <= 4'd0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MAC;
                        if (r_j == c_cols_m1) begin
                            r_j <= 4'd0;
                            r_i <= r_i + 4'd1;
                        end else begin
                            r_j <= r_j + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_matmul_sequencer: directed bench with a per-cycle reference model.
// Revision: 1.0
// ============================================================================
module tb_matmul_sequencer;

    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int INNER = 2;
    localparam int DW    = 6;
    localparam int NE    = ROWS * COLS;
    localparam int EC    = INNER + 1;
    localparam int TOTAL = NE * EC + 1;
    localparam int MAXV  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic [3:0]    a_addr;
    logic [3:0]    b_addr;
    logic [DW-1:0] product_out;
    logic [3:0]    reg_specifier;
    logic          update_reg;
    logic          busy;
    logic          done;

    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];

    assign a_data = a_mem[a_addr];
    assign b_data = b_mem[b_addr];

    matmul_sequencer #(.ROWS(ROWS), .COLS(COLS), .INNER(INNER), .DW(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .a_data        (a_data),
        .b_data        (b_data),
        .a_addr        (a_addr),
        .b_addr        (b_addr),
        .product_out   (product_out),
        .reg_specifier (reg_specifier),
        .update_reg    (update_reg),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_done = 0;
    int rf [16];
    int exp_c [16];
    bit running = 1'b0;
    int t = 0;
    int c;
    bit e_upd, e_done, e_busy;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Element value computed straight from the matrix definition.
    function automatic int calc(input int idx);
        int i, j, acc, s;
        i = idx / COLS;
        j = idx % COLS;
        acc = 0;
        for (int k = 0; k < INNER; k++) begin
            s = acc + int'(a_mem[i*INNER+k]) * int'(b_mem[k*COLS+j]);
`ifdef MATMUL_SEQ_SAT_EN
            acc = (s > MAXV) ? MAXV : s;
`else
            acc = s % (MAXV + 1);
`endif
        end
        return acc;
    endfunction

    // Model: a run occupies TOTAL cycles after the start edge; start ignored while running.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                running = 1'b0;
            end else if (running) begin
                if (t == TOTAL - 1) running = 1'b0;
                t++;
            end else if (start) begin
                running = 1'b1;
                t = 0;
                for (int e = 0; e < NE; e++) exp_c[e] = calc(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                c      = running ? t + 1 : 0;
                e_upd  = (c > 0) && (c < TOTAL) && (c % EC == 0);
                e_done = (c == TOTAL);
                e_busy = (c > 0);
                chk("busy", int'(busy), int'(e_busy));
                chk("update_reg", int'(update_reg), int'(e_upd));
                chk("done", int'(done), int'(e_done));
                if (e_upd) begin
                    chk("reg_specifier", int'(reg_specifier), c / EC - 1);
                    chk("product_out", int'(product_out), exp_c[c / EC - 1]);
                end
                if (update_reg) begin
                    n_wr++;
                    rf[reg_specifier] = int'(product_out);
                end
                if (done) n_done++;
            end
        end
    end

    task automatic clear_rf();
        for (int e = 0; e < 16; e++) rf[e] = -1;
    endtask

    task automatic fill(input int av, input int bv);
        for (int e = 0; e < 16; e++) begin
            a_mem[e] = DW'(av);
            b_mem[e] = DW'(bv);
        end
    endtask

    task automatic load_small();
        int av [4];
        int bv [8];
        av = '{1, 2, 3, 4};
        bv = '{1, 0, 2, 1, 0, 1, 1, 3};
        fill(0, 0);
        for (int e = 0; e < 4; e++) a_mem[e] = DW'(av[e]);
        for (int e = 0; e < 8; e++) b_mem[e] = DW'(bv[e]);
    endtask

    task automatic check_small(input string tag);
        int cv [8];
        cv = '{1, 2, 4, 7, 3, 4, 10, 15};
        for (int e = 0; e < 8; e++) chk($sformatf("%s_c%0d", tag, e), rf[e], cv[e]);
    endtask

    // Returns the cycle index (1 = first MAC cycle) at which done was seen.
    task automatic run_once(output int lat);
        clear_rf();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat, base_wr, base_done, cnt, d1, d2, dseen, exp0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(0, 0);
        clear_rf();
        repeat (3) @(negedge clk);
        chk("rst_update_reg", int'(update_reg), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product_out", int'(product_out), 0);
        chk("rst_reg_specifier", int'(reg_specifier), 0);
        chk("rst_a_addr", int'(a_addr), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        reset = 1'b0;

        // All ones: every element is INNER = 2.
        fill(1, 1);
        base_wr = n_wr;
        run_once(lat);
        chk("ones_latency", lat, 25);
        chk("ones_busy_after", int'(busy), 0);
        chk("ones_writes", n_wr - base_wr, 8);
        for (int e = 0; e < 8; e++) chk($sformatf("ones_c%0d", e), rf[e], 2);

        // 7*7 + 7*7 = 98: wraps to 34, or saturates at 63.
        fill(0, 0);
        a_mem[0] = 6'd7;
        a_mem[1] = 6'd7;
        b_mem[0] = 6'd7;
        b_mem[4] = 6'd7;
        run_once(lat);
`ifdef MATMUL_SEQ_SAT_EN
        exp0 = 63;
`else
        exp0 = 34;
`endif
        chk("sevens_c0", rf[0], exp0);
        chk("sevens_c1", rf[1], 0);
        chk("sevens_latency", lat, 25);

        load_small();
        run_once(lat);
        check_small("small");

        // start pulses during MAC (cycle 2) and WRITE (cycle 3) are ignored.
        base_wr = n_wr;
        base_done = n_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("restart_writes", n_wr - base_wr, 8);
        chk("restart_dones", n_done - base_done, 1);

        // Asynchronous reset in the middle of the third MAC cycle.
        fill(1, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        base_wr = n_wr;
        #1 reset = 1'b1;
        #1;
        chk("arst_update_reg", int'(update_reg), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_no_writes", n_wr - base_wr, 0);
        load_small();
        run_once(lat);
        chk("arst_latency", lat, 25);
        check_small("arst");

        // start held high: back-to-back runs with one IDLE cycle between.
        base_wr = n_wr;
        base_done = n_done;
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        d1 = -1;
        d2 = -1;
        dseen = 0;
        while (dseen < 2 && cnt < 120) begin
            @(negedge clk);
            cnt++;
            if (done) begin
                dseen++;
                if (d1 < 0) d1 = cnt;
                else d2 = cnt;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_first_done", d1, 25);
        chk("held_done_spacing", d2 - d1, 26);
        chk("held_writes", n_wr - base_wr, 16);
        chk("held_dones", n_done - base_done, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controls the matrix-multiply datapath. Computes C = A x B one result element at a time.
- For each element, fetches operand pairs from the A and B operand stores and accumulates their products over the inner dimension.
- Writes each finished 6-bit element into the 8-entry result register file through its product/specifier/update port.
- Sits between the top-level control (start/done) and the operand stores plus result register file.

Parameters:
- ROWS, 2, rows of A and of C
- COLS, 4, columns of B and of C; ROWS*COLS must be <= 8 (register file depth)
- INNER, 2, shared inner dimension (columns of A, rows of B); must be >= 1
- DW, 6, element width of operands and result

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  begin a multiply; sampled only in IDLE
- a_data  input  DW  A element at a_addr, valid combinationally in the same cycle
- b_data  input  DW  B element at b_addr, valid combinationally in the same cycle
- a_addr  output  4  A index, row-major: i*INNER+k
- b_addr  output  4  B index, row-major: k*COLS+j
- product_out  output  DW  result element to the register file
- reg_specifier  output  4  destination register: i*COLS+j
- update_reg  output  1  one-cycle write strobe to the register file
- busy  output  1  high from the first MAC cycle through DONE
- done  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, MAC, WRITE, DONE. All state and outputs are registered except a_addr/b_addr, which are driven directly from the registered counters i, j, k.
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; i=j=k=0; acc=0.
  - update_reg=0, done=0, busy=0, product_out=0, reg_specifier=0, a_addr=0, b_addr=0.
  - No partial write may be issued after reset asserts.
- IDLE:
  - start=1 -> MAC, with i=j=k=0 and acc=0.
  - start=0 -> stay in IDLE.
- MAC, one operand pair per cycle:
  - acc <= (acc + a_data*b_data) mod 2^DW. The full 2*DW-bit product is formed first, then the sum is truncated.
  - If k==INNER-1: load the final sum into product_out, set k=0, go to WRITE.
  - Otherwise: k++.
- WRITE:
  - update_reg=1 for exactly this cycle; reg_specifier=i*COLS+j; product_out holds the element.
  - Advance j; on j wrap (j==COLS-1) set j=0 and i++.
  - If i==ROWS-1 and j==COLS-1 -> DONE. Otherwise -> MAC with acc=0.
- DONE: done=1 for one cycle, then -> IDLE. busy drops in the cycle after DONE.
- Elements are written in ascending reg_specifier order, 0 to ROWS*COLS-1. Each index is written exactly once per run.
- Latency:
  - First MAC cycle immediately follows the start-sampling edge.
  - done is high ROWS*COLS*(INNER+1)+1 cycles after that edge: 25 cycles for the defaults.
- start while busy (MAC/WRITE/DONE): ignored, no queuing.
- start held high through DONE: a new run begins from IDLE on the next sampling edge.
- update_reg is never high outside WRITE. done is never high together with update_reg.
- The register file is never read or cleared by this block. Registers not written retain their values.

Optional Feature:
- Macro: MATMUL_SEQ_SAT_EN.
- Defined: accumulation saturates. If acc + product > 2^DW-1, acc becomes 2^DW-1 and stays there for the rest of that element's accumulation.
- Undefined: modulo-2^DW wrap, as described in Behaviour.
- Latency, handshake and ordering are identical in both builds.

Test Plan:
- All A=1, all B=1, start pulse:
  - update_reg pulses 8 times, reg_specifier 0..7 in order, product_out=2 each time.
  - done high 25 cycles after the start edge.
  - busy=0 afterward.
- A row0=[7,7], B col0=[7,7]:
  - element 0: 98 mod 64 = 34 without MATMUL_SEQ_SAT_EN; 63 with it.
- A=[[1,2],[3,4]], B=[[1,0,2,1],[0,1,1,3]]:
  - writes C = [1,2,4,7, 3,4,10,15] to specifiers 0..7.
- start re-asserted during MAC and during WRITE:
  - no restart; exactly 8 writes; exactly one done pulse.
- reset asserted asynchronously during the third MAC cycle:
  - update_reg/busy/done drop to 0 immediately; no further writes.
  - A fresh start afterward completes normally with correct values.
- start held high continuously:
  - back-to-back runs, each with 8 writes and one done.
  - Exactly one IDLE cycle between DONE and the next MAC.
